iob_rom_stream_rd: RTL and testbench

//  Read sequencer for one port of the dual-port ROM (addr/r_en in, registered r_data out, 1-cycle latency).
//  On a start command it reads len consecutive words from base_addr and emits them as a valid/ready stream.
//  It absorbs the ROM read latency with a 2-entry output FIFO, so consumer backpressure never loses a word.

---
 rtl/iob_rom_stream_rd.sv | 116 +++++++++++
 tb/tb_iob_rom_stream_rd.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/iob_rom_stream_rd.sv
// Read sequencer for one port of a 1-cycle-latency ROM: reads len words from base_addr
// and streams them out through a 2-entry FIFO that absorbs the read latency.
module iob_rom_stream_rd #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_r_en,
   input  logic [DATA_W-1:0] rom_r_data,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last
);

   localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] TWO = (ADDR_W+1)'(2);

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W:0]   len_q;
   logic [ADDR_W:0]   issued;
   logic [ADDR_W:0]   popped;
   logic [ADDR_W:0]   outstanding;
   logic              in_flight;
   logic [DATA_W-1:0] fifo_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic              pop;

   assign busy    = (state == RUN);
   assign m_valid = (count != 2'd0);
   assign pop     = m_valid & m_ready;
   assign m_data  = fifo_mem[rd_ptr];
   assign m_last  = m_valid & (popped == len_q - ONE);

   // Words issued but not yet popped live either on the ROM bus or in the FIFO;
   // counting this cycle's pop lets a full FIFO keep streaming at one word per cycle.
   assign outstanding = issued - popped - (ADDR_W+1)'(pop);
   assign rom_r_en    = busy & (issued < len_q) & (outstanding < TWO);
   assign rom_addr    = rom_r_en ? (base_q + issued[ADDR_W-1:0]) : addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         done        <= 1'b0;
         base_q      <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         issued      <= '0;
         popped      <= '0;
         in_flight   <= 1'b0;
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         count       <= 2'd0;
      end else begin
         done      <= 1'b0;
         in_flight <= rom_r_en;

         if (rom_r_en) begin
            addr_q <= rom_addr;
            issued <= issued + ONE;
         end

         if (in_flight) begin
            fifo_mem[wr_ptr] <= rom_r_data;
            wr_ptr           <= ~wr_ptr;
         end

         if (pop) begin
            rd_ptr <= ~rd_ptr;
            popped <= popped + ONE;
         end

         unique case ({in_flight, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase

         case (state)
            IDLE: begin
               if (start) begin
                  base_q <= base_addr;
                  len_q  <= len;
                  issued <= '0;
                  popped <= '0;
                  if (len == '0) done  <= 1'b1;
                  else           state <= RUN;
               end
            end
            RUN: begin
               if (pop && m_last) begin
                  state <= IDLE;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iob_rom_stream_rd.sv
// Bench for iob_rom_stream_rd: ROM model holds rom[i]=i, so every streamed word
// must equal (base+k) mod 2**ADDR_W for the k-th word of a command.
module tb_iob_rom_stream_rd;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 11;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W:0]   len = '0;
   logic              busy, done, rom_r_en, m_valid, m_last;
   logic              m_ready = 1'b0;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_r_data = '0;
   logic [DATA_W-1:0] m_data;

   logic [DATA_W-1:0] rom [DEPTH];
   int n_chk = 0;
   int n_pass = 0;

   iob_rom_stream_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .busy(busy), .done(done), .rom_addr(rom_addr), .rom_r_en(rom_r_en),
      .rom_r_data(rom_r_data), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_last(m_last));

   always #5 clk = ~clk;

   always_ff @(posedge clk) if (rom_r_en) rom_r_data <= rom[rom_addr];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   function automatic logic rdy(input int mode, input int cyc);
      case (mode)
         0:       return 1'b1;
         1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
         default: return 1'(($urandom % 2));
      endcase
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, " busy"},   busy, 0);
      chk({tag, " done"},   done, 0);
      chk({tag, " r_en"},   rom_r_en, 0);
      chk({tag, " addr"},   rom_addr, 0);
      chk({tag, " valid"},  m_valid, 0);
      chk({tag, " last"},   m_last, 0);
      chk({tag, " data"},   m_data, 0);
   endtask

   // Called at posedge+1 with the DUT idle; returns at posedge+1 after done was seen.
   task automatic run_cmd(input int b, input int l, input int mode,
                          output int first_d, output int last_d);
      int cyc, k, outst, bound;
      logic got_done, p;
      cyc = 0; k = 0; outst = 0; got_done = 0;
      first_d = -1; last_d = -1;
      bound = 8 * l + 40;
      start = 1'b1; base_addr = ADDR_W'(b); len = (ADDR_W+1)'(l);
      m_ready = rdy(mode, 0);
      while (!got_done && cyc < bound) begin
         @(negedge clk);
         p = m_valid & m_ready;
         if (rom_r_en) chk("issue limit", ((outst - int'(p)) < 2), 1);
         if (p) begin
            chk("word data", m_data, (b + k) % DEPTH);
            chk("word last", m_last, (k == l - 1));
            if (k == 0) first_d = int'(m_data);
            last_d = int'(m_data);
            k++;
         end
         if (done) got_done = 1'b1;
         if (rom_r_en) outst++;
         if (p) outst--;
         @(posedge clk); #1;
         start = 1'b0;
         cyc++;
         m_ready = rdy(mode, cyc);
      end
      chk("done seen", got_done, 1);
      chk("word count", k, l);
      chk("idle after", busy, 0);
   endtask

   typedef struct {
      int base;
      int len;
      int mode;
      int first;
      int lastw;
   } vec_t;

   initial begin
      vec_t vecs[7];
      int fd, ld;
      logic [DATA_W-1:0] got[$];
      int exp_seq[5];

      vecs = '{'{5,    4,    0, 5,    8},
               '{2046, 4,    0, 2046, 1},
               '{0,    8,    1, 0,    7},
               '{2040, 16,   2, 2040, 7},
               '{100,  1,    1, 100,  100},
               '{7,    2048, 0, 7,    6},
               '{2047, 3,    2, 2047, 1}};
      exp_seq = '{20, 21, 22, 40, 41};
      for (int i = 0; i < DEPTH; i++) rom[i] = DATA_W'(i);

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Cycle-accurate latency for base=5 len=4 with m_ready held high
      start = 1'b1; base_addr = 5; len = 4; m_ready = 1'b1;
      for (int c = 0; c <= 7; c++) begin
         @(negedge clk);
         case (c)
            0: chk("t0 busy", busy, 0);
            1: begin
               chk("t1 busy", busy, 1);
               chk("t1 r_en", rom_r_en, 1);
               chk("t1 addr", rom_addr, 5);
            end
            2: chk("t2 valid", m_valid, 0);
            3, 4, 5, 6: begin
               chk("tw valid", m_valid, 1);
               chk("tw data", m_data, 5 + c - 3);
               chk("tw last", m_last, (c == 6));
            end
            default: begin
               chk("t7 done", done, 1);
               chk("t7 busy", busy, 0);
            end
         endcase
         @(posedge clk); #1;
         start = 1'b0;
      end

      // len=0 completes without any read
      start = 1'b1; base_addr = 3; len = 0;
      for (int c = 0; c <= 2; c++) begin
         @(negedge clk);
         chk("len0 r_en", rom_r_en, 0);
         chk("len0 busy", busy, 0);
         chk("len0 done", done, (c == 1));
         @(posedge clk); #1;
         start = 1'b0;
      end

      // Start while busy is ignored; start in the done cycle runs immediately
      for (int c = 0; c <= 14; c++) begin
         start = (c == 0) || (c == 2) || (c == 6);
         base_addr = (c == 0) ? 11'd20 : (c == 2) ? 11'd500 : 11'd40;
         len = (c == 6) ? 12'd2 : 12'd3;
         m_ready = 1'b1;
         @(negedge clk);
         if (m_valid && m_ready) got.push_back(m_data);
         if (c == 6) begin
            chk("b2b done", done, 1);
            chk("b2b busy", busy, 0);
         end
         if (c == 7) begin
            chk("b2b busy2", busy, 1);
            chk("b2b addr", rom_addr, 40);
         end
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("b2b count", got.size(), 5);
      for (int i = 0; i < 5; i++)
         chk("b2b word", (i < got.size()) ? int'(got[i]) : -1, exp_seq[i]);

      // Reset in the middle of a len=10 command
      m_ready = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         start = (c == 0); base_addr = 0; len = 10;
         rst = (c == 4);
         @(negedge clk);
         if (c == 5) chk_reset_vals("midrst");
         @(posedge clk); #1;
      end
      start = 1'b0;
      run_cmd(5, 4, 0, fd, ld);
      chk("post-rst first", fd, 5);
      chk("post-rst last", ld, 8);

      foreach (vecs[i]) begin
         run_cmd(vecs[i].base, vecs[i].len, vecs[i].mode, fd, ld);
         chk("vec first", fd, vecs[i].first);
         chk("vec last", ld, vecs[i].lastw);
      end

      for (int i = 0; i < 12; i++)
         run_cmd(int'($urandom_range(DEPTH - 1)), int'($urandom_range(40)),
                 int'($urandom_range(2)), fd, ld);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
